// File: rtl/frame_hdr_pkg.sv
// frame_hdr_pkg: shared definitions for the frame header sequencer.
//   state_e      - sequencer states (idle, header, payload, done)
//   HDR_MAGIC    - upper half of header word 0
//   HDR_IDX_*    - header word positions
package frame_hdr_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHdr  = 2'd1,
    StPay  = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [15:0] HDR_MAGIC = 16'hA5A5;

  localparam int unsigned HDR_IDX_LEN = 0;  // {magic, length}
  localparam int unsigned HDR_IDX_SEQ = 1;  // sequence number

endpackage

// File: rtl/frame_hdr_ctrl.sv
// frame_hdr_ctrl: sequences one frame through the header/FIFO output mux.
// On Start it emits HDR_WORDS header words (Sel=1), then moves Pkt_Len payload
// words from the source FIFO to the destination FIFO (Sel=0), then pulses Done.
// Ports:
//   Clk, Reset           - clock, synchronous active-high reset
//   Start, Pkt_Len       - frame request and payload length (words), taken in idle
//   Src_Fifo_Empty       - source FIFO empty (first-word-fall-through)
//   Dst_Fifo_Full        - destination FIFO full
//   Sel, Header_data     - mux select (1 = header) and current header word
//   Src_Fifo_Rd_En       - source pop
//   Dst_Fifo_Wr_En       - destination push of the mux output
//   Busy, Done           - not idle; one-cycle end-of-frame pulse
module frame_hdr_ctrl #(
  parameter int unsigned HDR_WORDS = 2,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [LEN_WIDTH-1:0] Pkt_Len,
  input  logic                 Src_Fifo_Empty,
  input  logic                 Dst_Fifo_Full,
  output logic                 Sel,
  output logic [31:0]          Header_data,
  output logic                 Src_Fifo_Rd_En,
  output logic                 Dst_Fifo_Wr_En,
  output logic                 Busy,
  output logic                 Done
);
  import frame_hdr_pkg::*;

  localparam int unsigned   IdxW    = (HDR_WORDS > 1) ? $clog2(HDR_WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(HDR_WORDS - 1);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      hdr_idx_q, hdr_idx_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [31:0]          seq_q, seq_d;
  logic                 xfer;
  logic [15:0]          len16;

  always_comb begin
    state_d        = state_q;
    hdr_idx_d      = hdr_idx_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    seq_d          = seq_q;
    Sel            = 1'b1;
    Src_Fifo_Rd_En = 1'b0;
    Dst_Fifo_Wr_En = 1'b0;
    Busy           = 1'b1;
    Done           = 1'b0;
    // Payload moves only when a word is available and there is room for it.
    xfer           = !Src_Fifo_Empty && !Dst_Fifo_Full;

    unique case (state_q)
      StIdle: begin
        Busy = 1'b0;
        if (Start) begin
          len_d     = Pkt_Len;
          hdr_idx_d = '0;
          cnt_d     = '0;
          state_d   = StHdr;
        end
      end
      StHdr: begin
        Dst_Fifo_Wr_En = !Dst_Fifo_Full;
        if (!Dst_Fifo_Full) begin
          hdr_idx_d = hdr_idx_q + 1'b1;
          if (hdr_idx_q == LastIdx) begin
            state_d = (len_q != '0) ? StPay : StDone;
          end
        end
      end
      StPay: begin
        Sel            = 1'b0;
        Src_Fifo_Rd_En = xfer;
        Dst_Fifo_Wr_En = xfer;
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        Done    = 1'b1;
        seq_d   = seq_q + 32'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Word 0 carries the length zero-extended or truncated to 16 bits.
  assign len16 = 16'(len_q);

  always_comb begin
    Header_data = 32'h0;
    if (hdr_idx_q == IdxW'(HDR_IDX_LEN)) begin
      Header_data = {HDR_MAGIC, len16};
    end else if (hdr_idx_q == IdxW'(HDR_IDX_SEQ)) begin
      Header_data = seq_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      hdr_idx_q <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      seq_q     <= '0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      seq_q     <= seq_d;
    end
  end

endmodule

// File: tb/tb_frame_hdr_ctrl.sv
// tb_frame_hdr_ctrl: directed and randomized frames against a queue-based model
// of the source FIFO, the parent mux and the expected frame contents.
module tb_frame_hdr_ctrl;

  localparam int unsigned HdrWords = 2;
  localparam int unsigned LenWidth = 16;

  logic                clk;
  logic                reset;
  logic                start;
  logic [LenWidth-1:0] pkt_len;
  logic                src_fifo_empty;
  logic                dst_fifo_full;
  logic                sel;
  logic [31:0]         header_data;
  logic                src_fifo_rd_en;
  logic                dst_fifo_wr_en;
  logic                busy;
  logic                done;

  frame_hdr_ctrl #(
    .HDR_WORDS(HdrWords),
    .LEN_WIDTH(LenWidth)
  ) dut (
    .Clk           (clk),
    .Reset         (reset),
    .Start         (start),
    .Pkt_Len       (pkt_len),
    .Src_Fifo_Empty(src_fifo_empty),
    .Dst_Fifo_Full (dst_fifo_full),
    .Sel           (sel),
    .Header_data   (header_data),
    .Src_Fifo_Rd_En(src_fifo_rd_en),
    .Dst_Fifo_Wr_En(dst_fifo_wr_en),
    .Busy          (busy),
    .Done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] src_q[$];
  logic [31:0] dst_q[$];
  logic [31:0] exp_seq;
  int          cyc;
  int          n_pass;
  int          n_total;
  int          rd_cnt;
  int          en_err;
  int          done_cyc;
  int          first_wr;
  bit          rnd_mode;
  logic        s_sel, s_rd, s_wr, s_busy, s_done;
  logic [31:0] s_hdr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle: drive FIFO flags, observe at the falling edge, model the
  // FIFOs and the parent mux, then advance past the rising edge.
  task automatic cycle();
    dst_fifo_full  = rnd_mode && (cyc % 2 == 1);
    src_fifo_empty = (src_q.size() == 0) || (rnd_mode && ($urandom_range(0, 3) == 0));
    @(negedge clk);
    s_sel  = sel;
    s_rd   = src_fifo_rd_en;
    s_wr   = dst_fifo_wr_en;
    s_busy = busy;
    s_done = done;
    s_hdr  = header_data;
    if (s_wr) begin
      dst_q.push_back(s_sel ? s_hdr : ((src_q.size() > 0) ? src_q[0] : 32'hx));
      if (first_wr < 0) first_wr = cyc;
    end
    if (s_rd) begin
      if (src_q.size() == 0) en_err++;
      else void'(src_q.pop_front());
      rd_cnt++;
    end
    if (!s_sel && (s_rd !== s_wr)) en_err++;
    if (s_sel && s_rd) en_err++;
    if (s_done && done_cyc < 0) done_cyc = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_frame(input int len, input bit stall, input bit hold, input bit fixed_pay,
                           input string tag);
    logic [31:0] exp_q[$];
    logic [31:0] w;
    int          s;
    int          budget;
    exp_q.push_back({16'hA5A5, 16'(len)});
    exp_q.push_back(exp_seq);
    for (int i = 2; i < int'(HdrWords); i++) exp_q.push_back(32'h0);
    for (int i = 0; i < len; i++) begin
      w = fixed_pay ? 32'(32'h11 * (i + 1)) : $urandom;
      src_q.push_back(w);
      exp_q.push_back(w);
    end
    dst_q.delete();
    rd_cnt   = 0;
    en_err   = 0;
    done_cyc = -1;
    first_wr = -1;
    rnd_mode = stall;
    start    = 1'b1;
    pkt_len  = LenWidth'(len);
    s        = cyc;
    cycle();
    if (!hold) start = 1'b0;
    budget = 0;
    while (done_cyc < 0 && budget < 400) begin
      cycle();
      budget++;
    end
    start    = 1'b0;
    rnd_mode = 1'b0;
    check({tag, " done_seen"}, 32'(done_cyc >= 0), 32'd1);
    check({tag, " wr_count"}, dst_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      w = (i < dst_q.size()) ? dst_q[i] : 32'hx;
      check($sformatf("%s word%0d", tag, i), w, exp_q[i]);
    end
    check({tag, " rd_count"}, rd_cnt, len);
    check({tag, " enable_errs"}, en_err, 0);
    if (!stall) begin
      check({tag, " first_wr_lat"}, first_wr - s, 1);
      check({tag, " done_lat"}, done_cyc - s, HdrWords + len + 1);
    end
    src_q.delete();
    exp_seq = exp_seq + 32'd1;
  endtask

  initial begin
    int b;
    n_pass         = 0;
    n_total        = 0;
    cyc            = 0;
    exp_seq        = 32'h0;
    rnd_mode       = 1'b0;
    rd_cnt         = 0;
    en_err         = 0;
    done_cyc       = -1;
    first_wr       = -1;
    reset          = 1'b1;
    start          = 1'b0;
    pkt_len        = '0;
    src_fifo_empty = 1'b1;
    dst_fifo_full  = 1'b0;
    #1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    check("rst sel", s_sel, 1'b1);
    check("rst header", s_hdr, 32'hA5A5_0000);
    check("rst rd_en", s_rd, 1'b0);
    check("rst wr_en", s_wr, 1'b0);
    check("rst busy", s_busy, 1'b0);
    check("rst done", s_done, 1'b0);

    run_frame(3, 1'b0, 1'b0, 1'b1, "len3");
    cycle();

    // Start held through the first frame; the second must start in the idle cycle.
    run_frame(1, 1'b0, 1'b1, 1'b0, "b2b_a");
    run_frame(1, 1'b0, 1'b0, 1'b0, "b2b_b");
    cycle();

    run_frame(0, 1'b0, 1'b0, 1'b0, "len0");
    cycle();

    run_frame(4, 1'b1, 1'b0, 1'b0, "stall4");
    cycle();

    for (int k = 0; k < 6; k++) begin
      run_frame($urandom_range(0, 9), 1'($urandom_range(0, 1)), 1'b0, 1'b0,
                $sformatf("rnd%0d", k));
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) cycle();
    end

    // Reset in the middle of an 8-word payload.
    for (int i = 0; i < 8; i++) src_q.push_back($urandom);
    rd_cnt   = 0;
    en_err   = 0;
    start    = 1'b1;
    pkt_len  = LenWidth'(8);
    cycle();
    start = 1'b0;
    b = 0;
    while (rd_cnt < 1 && b < 50) begin
      cycle();
      b++;
    end
    check("midrst reached_pay", 32'(rd_cnt), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    check("midrst rd_en", s_rd, 1'b0);
    check("midrst wr_en", s_wr, 1'b0);
    check("midrst busy", s_busy, 1'b0);
    check("midrst header", s_hdr, 32'hA5A5_0000);
    src_q.delete();
    exp_seq = 32'h0;
    run_frame(2, 1'b0, 1'b0, 1'b0, "postrst");
    cycle();

    // Sequence number wrap: preload the counter in idle.
    force dut.seq_d = 32'hFFFF_FFFF;
    cycle();
    release dut.seq_d;
    exp_seq = 32'hFFFF_FFFF;
    run_frame(2, 1'b0, 1'b0, 1'b0, "wrap_a");
    cycle();
    run_frame(1, 1'b0, 1'b0, 1'b0, "wrap_b");
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
